// File: rtl/dbg_uart_bridge_pkg.sv
// Shared definitions for the UART debug bridge.
//   state_t : parser/access/response state encoding
//   CMD_*   : frame command bytes
//   ACK_BYTE: single-byte acknowledge returned for write and control frames
package dbg_uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_CTRL   = 3'd3,
        ST_ACCESS = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_C    = 8'h43;
    localparam logic [7:0] ACK_BYTE = 8'h06;

endpackage

// File: rtl/dbg_uart_bridge_shreg.sv
// 32-bit MSB-first byte shift register with a 2-bit byte counter.
// Collects incoming bytes (shift with din) or serialises a parallel word
// (load, then shift with din=0 while reading the top byte of nxt).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the byte counter (frame start)
//   shift      : shift din into the low byte, counter +1 (wraps 3->0)
//   load       : parallel load of load_val, counter cleared
//   din        : byte shifted in
//   load_val   : word for parallel load
//   nxt        : register value as it will be after this edge
//   cnt        : current byte count (3 means this shift completes the word)
module dbg_uart_bridge_shreg (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic        load,
    input  logic [7:0]  din,
    input  logic [31:0] load_val,
    output logic [31:0] nxt,
    output logic [1:0]  cnt
);

    logic [31:0] value_q, value_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (load) begin
            value_d = load_val;
            cnt_d   = 2'd0;
        end else if (shift) begin
            value_d = {value_q[23:0], din};
            cnt_d   = cnt_q + 2'd1;
        end
        if (clr) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 32'h0;
            cnt_q   <= 2'd0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    // Exposing the next value lets the parent latch a word in the same
    // cycle its final byte arrives.
    assign nxt = value_d;
    assign cnt = cnt_q;

endmodule

// File: rtl/dbg_uart_bridge.sv
// UART-driven debug bridge: parses W/R/C frames from a byte stream, performs
// a fixed-length memory access on the debug bus and returns an ACK or the
// four read-data bytes, MSB first.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rx_data, rx_valid     : received UART byte and its one-cycle strobe
//   tx_data, tx_valid,
//   tx_ready              : response byte stream with valid/ready handshake
//   dbg_mem_op, dbg_wren,
//   dbg_adr, dbg_do,
//   dbg_di                : debug memory bus
//   cpu_n_reset           : CPU reset (active low), set by control frames
module dbg_uart_bridge
    import dbg_uart_bridge_pkg::*;
#(
    parameter int ACC_CYCLES = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    output logic        cpu_n_reset
);

    localparam int ACW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ACW-1:0] ACC_LAST = ACW'(ACC_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [ACW-1:0] acc_cnt_q, acc_cnt_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           is_read_q, is_read_d;
    logic           mem_op_q, mem_op_d;
    logic [3:0]     wren_q, wren_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    do_q, do_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           n_rst_q, n_rst_d;

    logic        adr_clr, adr_shift, dat_clr, dat_shift, rsp_shift, rsp_load;
    logic [31:0] adr_nxt, dat_nxt, rsp_nxt;
    logic [1:0]  adr_cnt, dat_cnt, rsp_cnt;
    logic        in_frame;
    logic        unused_rsp_low;

    dbg_uart_bridge_shreg u_adr_sr (
        .clk      (clk),
        .reset    (reset),
        .clr      (adr_clr),
        .shift    (adr_shift),
        .load     (1'b0),
        .din      (rx_data),
        .load_val (32'h0),
        .nxt      (adr_nxt),
        .cnt      (adr_cnt)
    );

    dbg_uart_bridge_shreg u_dat_sr (
        .clk      (clk),
        .reset    (reset),
        .clr      (dat_clr),
        .shift    (dat_shift),
        .load     (1'b0),
        .din      (rx_data),
        .load_val (32'h0),
        .nxt      (dat_nxt),
        .cnt      (dat_cnt)
    );

    // Read-response serialiser: loaded with dbg_di, top byte is the next
    // byte to present.
    dbg_uart_bridge_shreg u_rsp_sr (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .shift    (rsp_shift),
        .load     (rsp_load),
        .din      (8'h00),
        .load_val (dbg_di),
        .nxt      (rsp_nxt),
        .cnt      (rsp_cnt)
    );

    assign unused_rsp_low = ^rsp_nxt[23:0];
    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                      (state_q == ST_CTRL);

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        is_read_d  = is_read_q;
        mem_op_d   = mem_op_q;
        wren_d     = wren_q;
        adr_d      = adr_q;
        do_d       = do_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        n_rst_d    = n_rst_q;
        adr_clr    = 1'b0;
        adr_shift  = 1'b0;
        dat_clr    = 1'b0;
        dat_shift  = 1'b0;
        rsp_shift  = 1'b0;
        rsp_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        state_d   = ST_ADDR;
                        is_read_d = (rx_data == CMD_R);
                        adr_clr   = 1'b1;
                        dat_clr   = 1'b1;
                    end else if (rx_data == CMD_C) begin
                        state_d   = ST_CTRL;
                        is_read_d = 1'b0;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    adr_shift = 1'b1;
                    if (adr_cnt == 2'd3) begin
                        if (is_read_q) begin
                            // Address completes with this byte: latch the
                            // shifted-in value and start the access.
                            state_d   = ST_ACCESS;
                            mem_op_d  = 1'b1;
                            wren_d    = 4'h0;
                            adr_d     = adr_nxt;
                            acc_cnt_d = '0;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    dat_shift = 1'b1;
                    if (dat_cnt == 2'd3) begin
                        state_d   = ST_ACCESS;
                        mem_op_d  = 1'b1;
                        wren_d    = 4'hF;
                        adr_d     = adr_nxt;
                        do_d      = dat_nxt;
                        acc_cnt_d = '0;
                    end
                end
            end
            ST_CTRL: begin
                if (rx_valid) begin
                    n_rst_d    = rx_data[0];
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end
            end
            ST_ACCESS: begin
                if (acc_cnt_q == ACC_LAST) begin
                    mem_op_d   = 1'b0;
                    wren_d     = 4'h0;
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    if (is_read_q) begin
                        // Sample read data on the last access cycle.
                        rsp_load  = 1'b1;
                        tx_data_d = rsp_nxt[31:24];
                    end else begin
                        tx_data_d = ACK_BYTE;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q + ACW'(1);
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    if (is_read_q) begin
                        // Also shifts on the final byte so the count wraps to 0.
                        rsp_shift = 1'b1;
                    end
                    if (is_read_q && rsp_cnt != 2'd3) begin
                        tx_data_d = rsp_nxt[31:24];
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte timeout while a frame is being received.
        if (in_frame) begin
            if (rx_valid) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d = '0;
                state_d   = ST_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            is_read_q  <= 1'b0;
            mem_op_q   <= 1'b0;
            wren_q     <= 4'h0;
            adr_q      <= 32'h0;
            do_q       <= 32'h0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            n_rst_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            is_read_q  <= is_read_d;
            mem_op_q   <= mem_op_d;
            wren_q     <= wren_d;
            adr_q      <= adr_d;
            do_q       <= do_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            n_rst_q    <= n_rst_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign dbg_mem_op  = mem_op_q;
    assign dbg_wren    = wren_q;
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign cpu_n_reset = n_rst_q;

endmodule

// File: tb/tb_dbg_uart_bridge.sv
module tb_dbg_uart_bridge;

    localparam int ACC = 2;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        cpu_n_reset;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;   // 0: always ready, 1: ready 1 of 3 cycles, 2: never
    logic [7:0] exp_q[$];

    dbg_uart_bridge #(.ACC_CYCLES(ACC), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dbg_mem_op  (dbg_mem_op),
        .dbg_wren    (dbg_wren),
        .dbg_adr     (dbg_adr),
        .dbg_do      (dbg_do),
        .dbg_di      (dbg_di),
        .cpu_n_reset (cpu_n_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // tx_ready pattern generator
    initial begin
        int ph;
        ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (rdy_mode == 0) || (rdy_mode == 1 && ph == 0);
            ph = (ph + 1) % 3;
        end
    end

    // Scoreboard: pop an expected byte on every handshake, check holding on stall.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("tx_hold", {24'h0, tx_data}, {24'h0, prev_data});
                if (tx_valid && tx_ready) begin
                    check("tx_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                    if (exp_q.size() != 0) begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("tx_byte", {24'h0, tx_data}, {24'h0, e});
                        $display("tx byte %02h (expected %02h)", tx_data, e);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // Called at posedge+1; leaves at posedge+1 after the byte was sampled.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || tx_valid); i++) idle(1);
        check(tag, {31'h0, exp_q.size() == 0 && !tx_valid}, 32'h1);
    endtask

    task automatic push4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        dbg_di   = 32'h0;
        idle(3);
        check("rst_mem_op", {31'h0, dbg_mem_op}, 32'h0);
        check("rst_wren", {28'h0, dbg_wren}, 32'h0);
        check("rst_adr", dbg_adr, 32'h0);
        check("rst_do", dbg_do, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h0);
        reset = 1'b0;
        idle(1);

        // Write 0 <- 000000AA
        exp_q.push_back(8'h06);
        send(8'h57); send4(32'h0); send4(32'h000000AA);
        check("w1_op_c1", {31'h0, dbg_mem_op}, 32'h1);
        check("w1_wren", {28'h0, dbg_wren}, 32'hF);
        check("w1_adr", dbg_adr, 32'h0);
        check("w1_do", dbg_do, 32'hAA);
        idle(1);
        check("w1_op_c2", {31'h0, dbg_mem_op}, 32'h1);
        check("w1_do_c2", dbg_do, 32'hAA);
        idle(1);
        check("w1_op_end", {31'h0, dbg_mem_op}, 32'h0);
        check("w1_wren_end", {28'h0, dbg_wren}, 32'h0);
        check("w1_do_hold", dbg_do, 32'hAA);
        check("w1_tx_valid", {31'h0, tx_valid}, 32'h1);
        wait_drain("w1_drain");

        // Read 00020020 -> 000000CC
        dbg_di = 32'h000000CC;
        push4(32'h000000CC);
        send(8'h52); send4(32'h00020020);
        check("r1_op", {31'h0, dbg_mem_op}, 32'h1);
        check("r1_wren", {28'h0, dbg_wren}, 32'h0);
        check("r1_adr", dbg_adr, 32'h00020020);
        idle(2);
        check("r1_op_end", {31'h0, dbg_mem_op}, 32'h0);
        check("r1_adr_hold", dbg_adr, 32'h00020020);
        wait_drain("r1_drain");

        // Unknown byte in IDLE: no response
        send(8'h11);
        idle(4);
        check("junk_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("junk_op", {31'h0, dbg_mem_op}, 32'h0);

        // Write with bytes dropped during ACCESS/RESP, response stalled past TIMEOUT
        rdy_mode = 2;
        exp_q.push_back(8'h06);
        send(8'h57); send4(32'h12345678); send4(32'hDEADBEEF);
        check("w2_adr", dbg_adr, 32'h12345678);
        check("w2_do", dbg_do, 32'hDEADBEEF);
        send(8'h52);
        check("w2_op_c2", {31'h0, dbg_mem_op}, 32'h1);
        check("w2_adr_c2", dbg_adr, 32'h12345678);
        idle(1);
        check("w2_op_end", {31'h0, dbg_mem_op}, 32'h0);
        send(8'h43);
        idle(TMO + 10);
        check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("stall_tx_data", {24'h0, tx_data}, 32'h06);
        rdy_mode = 0;
        wait_drain("w2_drain");

        // Read with tx_ready 1 of 3 cycles
        rdy_mode = 1;
        dbg_di = 32'hA1B2C3D4;
        push4(32'hA1B2C3D4);
        send(8'h52); send4(32'hCAFE0004);
        check("r2_adr", dbg_adr, 32'hCAFE0004);
        wait_drain("r2_drain");
        rdy_mode = 0;
        idle(2);

        // Control frames
        exp_q.push_back(8'h06);
        send(8'h43); send(8'h01);
        check("c1_n_reset", {31'h0, cpu_n_reset}, 32'h1);
        check("c1_tx_valid", {31'h0, tx_valid}, 32'h1);
        wait_drain("c1_drain");
        exp_q.push_back(8'h06);
        send(8'h43); send(8'hFE);
        check("c2_n_reset", {31'h0, cpu_n_reset}, 32'h0);
        wait_drain("c2_drain");

        // TIMEOUT-1 idle cycles: frame survives
        dbg_di = 32'h11223344;
        push4(32'h11223344);
        send(8'h52); send(8'h00);
        idle(TMO - 1);
        send(8'h03); send(8'h00); send(8'h00);
        check("tmo_edge_op", {31'h0, dbg_mem_op}, 32'h1);
        check("tmo_edge_adr", dbg_adr, 32'h00030000);
        wait_drain("tmo_edge_drain");

        // TIMEOUT idle cycles: partial write discarded
        dbg_di = 32'h5A5A0F0F;
        push4(32'h5A5A0F0F);
        send(8'h57); send(8'h00); send(8'h01);
        idle(TMO);
        send(8'h52); send4(32'h00010000);
        check("tmo_op", {31'h0, dbg_mem_op}, 32'h1);
        check("tmo_wren", {28'h0, dbg_wren}, 32'h0);
        check("tmo_adr", dbg_adr, 32'h00010000);
        wait_drain("tmo_drain");

        // Reset in the second ACCESS cycle of a write
        exp_q.push_back(8'h06);
        send(8'h43); send(8'h01);
        wait_drain("pre_rst_drain");
        send(8'h57); send4(32'h00000010); send4(32'h00000055);
        idle(1);
        check("mid_rst_op_before", {31'h0, dbg_mem_op}, 32'h1);
        reset = 1'b1;
        idle(1);
        check("mid_rst_op", {31'h0, dbg_mem_op}, 32'h0);
        check("mid_rst_wren", {28'h0, dbg_wren}, 32'h0);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_n_reset", {31'h0, cpu_n_reset}, 32'h0);
        reset = 1'b0;
        send(8'h42);
        idle(5);
        check("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("post_rst_op", {31'h0, dbg_mem_op}, 32'h0);
        exp_q.push_back(8'h06);
        send(8'h43); send(8'h01);
        check("post_rst_ctrl", {31'h0, cpu_n_reset}, 32'h1);
        wait_drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_uart_bridge.md
DBG_UART_BRIDGE -- requirements
Module: dbg_uart_bridge

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 2: cycles dbg_mem_op is held per access (min 1).
REQ-002 SHALL have parameter TIMEOUT, default 1000000: idle clk cycles between frame bytes before the parser aborts.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received UART byte.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  out  8  response byte to UART transmitter.
REQ-008 tx_valid  out  1  tx_data valid.
REQ-009 tx_ready  in  1  transmitter accepts byte when high with tx_valid.
REQ-010 dbg_mem_op  out  1  debug port owns memory bus.
REQ-011 dbg_wren  out  4  byte write enables.
REQ-012 dbg_adr  out  32  debug address.
REQ-013 dbg_do  out  32  debug write data.
REQ-014 dbg_di  in  32  debug read data.
REQ-015 cpu_n_reset  out  1  CPU reset, active low.

Function
REQ-016 Frames SHALL be: 'W'(0x57)+4 addr+4 data; 'R'(0x52)+4 addr; 'C'(0x43)+1 ctrl byte; multi-byte fields MSB first.
REQ-017 States SHALL be IDLE, ADDR, DATA, CTRL, ACCESS, RESP.
REQ-018 IDLE: 'W'/'R' -> ADDR, 'C' -> CTRL, any other byte ignored (stay IDLE, no response).
REQ-019 ADDR: after 4th byte, 'W' -> DATA, 'R' -> ACCESS; DATA: after 4th byte -> ACCESS.
REQ-020 ACCESS SHALL start the cycle after the final frame byte, drive dbg_mem_op=1 with dbg_adr/dbg_do stable for exactly ACC_CYCLES cycles, dbg_wren=4'hF for 'W' and 4'h0 for 'R'.
REQ-021 'R' SHALL capture dbg_di on the last ACCESS cycle.
REQ-022 On leaving ACCESS, dbg_mem_op and dbg_wren SHALL return to 0; dbg_adr/dbg_do hold last value.
REQ-023 RESP SHALL assert tx_valid the cycle after ACCESS ends (or after the CTRL byte); 'W'/'C' send 0x06; 'R' sends 4 bytes of captured data MSB first.
REQ-024 tx_data SHALL be stable while tx_valid=1 and tx_ready=0; a byte transfers on a cycle with both high; next byte (if any) presented the following cycle.
REQ-025 After the last response byte transfers, state SHALL return to IDLE.
REQ-026 CTRL: cpu_n_reset SHALL take ctrl byte bit0 on the cycle after the byte; other bits ignored.
REQ-027 rx_valid during ACCESS or RESP SHALL be dropped without effect.
REQ-028 TIMEOUT idle cycles in ADDR/DATA/CTRL SHALL return to IDLE, no access, no response; counter restarts on each rx_valid.
REQ-029 tx_ready held low indefinitely SHALL stall RESP with no timeout.
REQ-030 Address/data byte counter SHALL be 2-bit, wrapping 3->0 on the field's final byte.

Reset
REQ-031 reset SHALL override all activity on the next edge, including mid-ACCESS or mid-RESP.
REQ-032 Reset values: state IDLE, dbg_mem_op 0, dbg_wren 0, dbg_adr 0, dbg_do 0, tx_valid 0, tx_data 0, cpu_n_reset 0 (CPU held in reset), counters 0.

Structure
REQ-033 Package dbg_uart_bridge_pkg SHALL hold state enum, command codes 0x57/0x52/0x43 and ACK 0x06.
REQ-034 One sub-module dbg_uart_bridge_shreg (32-bit MSB-first byte shift/collect register with 2-bit count) SHALL be used for address, data and read-response serialisation.

Verification
REQ-035 Bytes 57 00 00 00 00 00 00 00 AA -> dbg_mem_op=1, dbg_wren=F, dbg_adr=0, dbg_do=AA for 2 cycles, then tx 0x06.
REQ-036 Bytes 52 00 02 00 20, dbg_di=000000CC -> wren=0, adr=00020020, tx 00 00 00 CC in order.
REQ-037 'R' response with tx_ready toggling 1-of-3 cycles -> each byte held stable, 4 bytes once each, no loss.
REQ-038 Bytes 43 01 -> cpu_n_reset 0->1, tx 0x06; bytes 43 FE -> cpu_n_reset 0, tx 0x06.
REQ-039 Byte 57, 2 addr bytes, TIMEOUT idle cycles, then 52 00 01 00 00 -> first frame discarded, read of 00010000 performed.
REQ-040 reset asserted in 2nd ACCESS cycle of a write -> next edge dbg_mem_op=0, tx_valid=0, cpu_n_reset=0, state IDLE; 0x42 byte then ignored.
